// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the thinpad SRAM bank arbiter.
// Used by sram_arb_pick and sram_arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W    = 20;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_RD_CYCLES = 2;
  localparam int DEF_WR_CYCLES = 3;
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner select between the fetch and data requesters.
// SRAM_ARBITER_RR_EN: round-robin on ties; otherwise fixed data priority.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic   i_fetch_req,
  input  logic   i_data_req,
`ifdef SRAM_ARBITER_RR_EN
  input  owner_t i_last_own,
`endif
  output logic   o_valid,
  output owner_t o_owner
);

  always_comb begin
    o_valid = i_fetch_req | i_data_req;
    o_owner = i_data_req ? OWN_D : OWN_I;
`ifdef SRAM_ARBITER_RR_EN
    // On a tie the port that did not win last time goes first.
    if (i_fetch_req && i_data_req)
      o_owner = (i_last_own == OWN_D) ? OWN_I : OWN_D;
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for one asynchronous 32-bit SRAM bank.
// Optional SRAM_ARBITER_RR_EN selects round-robin arbitration.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_CYCLES = DEF_RD_CYCLES,
  parameter int WR_CYCLES = DEF_WR_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_done,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_done,
  output logic [DATA_W-1:0]     d_rdata,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata,
  output logic                  sram_data_oe,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  owner_t             r_own, w_own_nxt;
  logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
  logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
  logic [BE_W-1:0]    r_be_n, w_be_n_nxt;
  logic               r_ce_n, w_ce_n_nxt;
  logic               r_oe_n, w_oe_n_nxt;
  logic               r_we_n, w_we_n_nxt;
  logic               r_data_oe, w_data_oe_nxt;
  logic               r_i_done, w_i_done_nxt;
  logic               r_d_done, w_d_done_nxt;
  logic [DATA_W-1:0]  r_i_rdata, r_d_rdata;
  logic               w_i_cap, w_d_cap;
  logic               w_i_gnt, w_d_gnt;
  logic               w_pick_valid;
  owner_t             w_pick_own;

`ifdef SRAM_ARBITER_RR_EN
  owner_t r_last_own;

  always_ff @(posedge clk) begin
    if (!rst)
      r_last_own <= OWN_I;
    else if (w_i_gnt || w_d_gnt)
      r_last_own <= w_pick_own;
  end
`endif

  sram_arb_pick u_pick (
    .i_fetch_req (i_req),
    .i_data_req  (d_req),
`ifdef SRAM_ARBITER_RR_EN
    .i_last_own  (r_last_own),
`endif
    .o_valid     (w_pick_valid),
    .o_owner     (w_pick_own)
  );

  // Next values for every pin are computed here and registered below, so the
  // strobes leave the block straight from flops.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_own_nxt     = r_own;
    w_addr_nxt    = r_addr;
    w_wdata_nxt   = r_wdata;
    w_be_n_nxt    = r_be_n;
    w_ce_n_nxt    = r_ce_n;
    w_oe_n_nxt    = r_oe_n;
    w_we_n_nxt    = r_we_n;
    w_data_oe_nxt = r_data_oe;
    w_i_done_nxt  = 1'b0;
    w_d_done_nxt  = 1'b0;
    w_i_cap       = 1'b0;
    w_d_cap       = 1'b0;
    w_i_gnt       = 1'b0;
    w_d_gnt       = 1'b0;

    case (r_state)
      IDLE: begin
        if (rst && w_pick_valid) begin
          w_own_nxt  = w_pick_own;
          w_ce_n_nxt = 1'b0;
          if (w_pick_own == OWN_D) begin
            w_d_gnt    = 1'b1;
            w_addr_nxt = d_addr;
            w_be_n_nxt = ~d_be;
            if (d_we) begin
              w_wdata_nxt   = d_wdata;
              w_we_n_nxt    = 1'b0;
              w_data_oe_nxt = 1'b1;
              w_cnt_nxt     = WR_LOAD;
              w_state_nxt   = WRITE;
            end else begin
              w_oe_n_nxt  = 1'b0;
              w_cnt_nxt   = RD_LOAD;
              w_state_nxt = READ;
            end
          end else begin
            w_i_gnt     = 1'b1;
            w_addr_nxt  = i_addr;
            w_be_n_nxt  = '0;
            w_oe_n_nxt  = 1'b0;
            w_cnt_nxt   = RD_LOAD;
            w_state_nxt = READ;
          end
        end
      end
      READ: begin
        if (r_cnt == '0) begin
          w_state_nxt = DONE;
          w_ce_n_nxt  = 1'b1;
          w_oe_n_nxt  = 1'b1;
          w_be_n_nxt  = '1;
          if (r_own == OWN_D) begin
            w_d_cap      = 1'b1;
            w_d_done_nxt = 1'b1;
          end else begin
            w_i_cap      = 1'b1;
            w_i_done_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      WRITE: begin
        // data_oe stays high into DONE to give the SRAM data hold time.
        if (r_cnt == '0) begin
          w_state_nxt  = DONE;
          w_ce_n_nxt   = 1'b1;
          w_we_n_nxt   = 1'b1;
          w_be_n_nxt   = '1;
          w_d_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      DONE: begin
        w_state_nxt   = IDLE;
        w_data_oe_nxt = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_own     <= OWN_I;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be_n    <= '1;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_data_oe <= 1'b0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_own     <= w_own_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_be_n    <= w_be_n_nxt;
      r_ce_n    <= w_ce_n_nxt;
      r_oe_n    <= w_oe_n_nxt;
      r_we_n    <= w_we_n_nxt;
      r_data_oe <= w_data_oe_nxt;
      r_i_done  <= w_i_done_nxt;
      r_d_done  <= w_d_done_nxt;
      if (w_i_cap) r_i_rdata <= sram_rdata;
      if (w_d_cap) r_d_rdata <= sram_rdata;
    end
  end

  assign i_gnt        = w_i_gnt;
  assign d_gnt        = w_d_gnt;
  assign i_done       = r_i_done;
  assign d_done       = r_d_done;
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;
  assign sram_addr    = r_addr;
  assign sram_wdata   = r_wdata;
  assign sram_data_oe = r_data_oe;
  assign sram_ce_n    = r_ce_n;
  assign sram_oe_n    = r_oe_n;
  assign sram_we_n    = r_we_n;
  assign sram_be_n    = r_be_n;
  assign busy         = (r_state != IDLE);

endmodule
